// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides and a one-entry output register.
// Optional iterative shift-add multiplier on opcode 1000 when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE, HOLD, MUL_BUSY} state_t;
  localparam logic [SHW:0] MUL_LAST = (SHW+1)'(WIDTH);
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v, r_err;

  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_add, w_sub, w_shl, w_shr;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_err;
  logic             w_accept, w_load, w_is_mul;
  logic             w_mul_start, w_mul_done;

  assign w_amt = in_b[SHW-1:0];
  assign w_add = {1'b0, in_a} + {1'b0, in_b};
  assign w_sub = {1'b0, in_a} - {1'b0, in_b};
  // One extra bit on the far side of each shift catches the last bit shifted out.
  assign w_shl = {1'b0, in_a} << w_amt;
  assign w_shr = {in_a, 1'b0} >> w_amt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (opcode)
      4'b0000: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (in_a[MSB] == in_b[MSB]) && (w_add[MSB] != in_a[MSB]);
      end
      4'b0001: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (in_a[MSB] != in_b[MSB]) && (w_sub[MSB] != in_a[MSB]);
      end
      4'b0010: w_res = in_a & in_b;
      4'b0011: w_res = in_a | in_b;
      4'b0100: w_res = in_a ^ in_b;
      4'b0101: w_res = ~in_a;
      4'b0110: begin
        w_res = w_shl[MSB:0];
        w_c   = w_shl[WIDTH];
      end
      4'b0111: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
`ifdef ALU_PIPE_MUL_EN
      4'b1000: ;
`endif
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  assign w_is_mul = (opcode == 4'b1000);
  assign in_ready = (r_state != MUL_BUSY) && ((r_state != HOLD) || out_ready);
`else
  assign w_is_mul = 1'b0;
  assign in_ready = (r_state != HOLD) || out_ready;
`endif

  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == HOLD);

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] r_mul_acc, r_mul_mcand;
  logic [WIDTH-1:0]   r_mul_mplier;
  logic [SHW:0]       r_mul_cnt;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_mul_start  = 1'b0;
    w_mul_done   = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (w_accept) begin
          if (w_is_mul) begin
`ifdef ALU_PIPE_MUL_EN
            w_state_next = MUL_BUSY;
`endif
            w_mul_start  = 1'b1;
          end else begin
            w_state_next = HOLD;
            w_load       = 1'b1;
          end
        end else if ((r_state == HOLD) && out_ready) begin
          w_state_next = IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      MUL_BUSY: begin
        if (r_mul_cnt == MUL_LAST) begin
          w_state_next = HOLD;
          w_mul_done   = 1'b1;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_n      <= w_res[MSB];
        r_c      <= w_c;
        r_v      <= w_v;
        r_err    <= w_err;
      end
`ifdef ALU_PIPE_MUL_EN
      else if (w_mul_done) begin
        r_result <= r_mul_acc[MSB:0];
        r_z      <= (r_mul_acc[MSB:0] == '0);
        r_n      <= r_mul_acc[MSB];
        r_c      <= |r_mul_acc[2*WIDTH-1:WIDTH];
        r_v      <= 1'b0;
        r_err    <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_PIPE_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= {{WIDTH{1'b0}}, in_a};
      r_mul_mplier <= in_b;
      r_mul_cnt    <= '0;
    end else if ((r_state == MUL_BUSY) && (r_mul_cnt != MUL_LAST)) begin
      if (r_mul_mplier[0])
        r_mul_acc <= r_mul_acc + r_mul_mcand;
      r_mul_mcand  <= r_mul_mcand << 1;
      r_mul_mplier <= r_mul_mplier >> 1;
      r_mul_cnt    <= r_mul_cnt + 1'b1;
    end
  end
`endif

  assign result = r_result;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: arithmetic reference model plus a per-cycle output checker.
module tb_alu_pipe;
  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   fl;   // {z,n,c,v,err}
    int           rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
    return op == 4'b1000;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    int              amt;
    longint          sa, sb, s, lim;
    longint unsigned ua, ub, p;
    logic            c, v, er;
    logic [W-1:0]    r;
    amt = int'(b[SHW-1:0]);
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    lim = 64'sd1 <<< (W - 1);
    c = 1'b0; v = 1'b0; er = 1'b0; r = '0;
    case (op)
      4'd0: begin s = sa + sb; r = W'(ua + ub); c = (ua + ub) >= (64'd1 << W); v = (s >= lim) || (s < -lim); end
      4'd1: begin s = sa - sb; r = W'(ua - ub); c = ua < ub; v = (s >= lim) || (s < -lim); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = W'(ua << amt); c = (amt == 0) ? 1'b0 : a[W - amt]; end
      4'd7: begin r = W'(ua >> amt); c = (amt == 0) ? 1'b0 : a[amt - 1]; end
      default: begin
        if (is_mul(op)) begin
          p = ua * ub;
          r = W'(p);
          c = (p >> W) != 0;
        end else begin
          er = 1'b1;
        end
      end
    endcase
    e.res = r;
    e.fl  = {(r == '0), r[W-1], c, v, er};
    e.rdy = 0;
    return e;
  endfunction

  // Per-cycle checker: expected handshake and output register contents from the model queue.
  always @(negedge clk) begin
    bit   exp_valid, busy, exp_ir;
    exp_t e;
    if (armed) begin
      exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      busy      = (q.size() > 0) && (q[0].rdy > cyc);
      exp_ir    = !busy && (!exp_valid || out_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_ir);
      if (exp_valid) begin
        chk("result", result, q[0].res);
        chk("flags_znvcv_err", {flag_z, flag_n, flag_c, flag_v, err}, q[0].fl);
      end
      if (rst) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) begin
          e     = model(opcode, in_a, in_b);
          e.rdy = cyc + (is_mul(opcode) ? W + 1 : 1);
          q.push_back(e);
        end
      end
    end
    cyc++;
  end

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    opcode   = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1 for opcode %0h", op);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] r, input logic [4:0] fl);
    exp_t e;
    e = model(op, a, b);
    chk({name, "_res"}, e.res, r);
    chk({name, "_flags"}, e.fl, fl);
  endtask

  initial begin
    // Hand-computed anchors for the reference model ({z,n,c,v,err}).
    pin("pin_add_ovf",  4'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010);
    pin("pin_sub_brw",  4'd1, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100);
    pin("pin_add_wrap", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100);
    pin("pin_shl1",     4'd6, 16'h8001, 16'h0001, 16'h0002, 5'b00100);
    pin("pin_shr2",     4'd7, 16'h0003, 16'h0002, 16'h0000, 5'b10100);
    pin("pin_shl0",     4'd6, 16'h1234, 16'h0000, 16'h1234, 5'b00000);
    pin("pin_illegal",  4'hF, 16'h1234, 16'h5678, 16'h0000, 5'b10001);
`ifdef ALU_PIPE_MUL_EN
    pin("pin_mul",      4'd8, 16'h0102, 16'h0003, 16'h0306, 5'b00000);
    pin("pin_mul_hi",   4'd8, 16'h1000, 16'h0010, 16'h0000, 5'b10100);
`else
    pin("pin_mul_off",  4'd8, 16'h0102, 16'h0003, 16'h0000, 5'b10001);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("reset_result", result, 16'h0000);
    chk("reset_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b00000);
    chk("reset_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Back-to-back directed vectors with downstream always ready.
    drive(4'd0, 16'h7FFF, 16'h0001);
    drive(4'd1, 16'h0003, 16'h0005);
    drive(4'd0, 16'hFFFF, 16'h0001);
    drive(4'd6, 16'h8001, 16'h0001);
    drive(4'd7, 16'h0003, 16'h0002);
    drive(4'd6, 16'h1234, 16'h0000);
    drive(4'd6, 16'h00F1, 16'h000F);
    drive(4'd7, 16'h8000, 16'h000F);
    drive(4'd1, 16'h8000, 16'h0001);
    drive(4'd2, 16'hF0F0, 16'hFF00);
    drive(4'd3, 16'hF0F0, 16'h0F00);
    drive(4'd4, 16'hAAAA, 16'hFFFF);
    drive(4'd5, 16'h0000, 16'h1234);
    drive(4'hF, 16'h1234, 16'h5678);
    drive(4'h9, 16'h0001, 16'h0001);
    idle(3);

    // Backpressure: downstream stalls for 4 cycles, then results drain in order.
    out_ready = 1'b0;
    fork
      begin
        drive(4'd0, 16'h0001, 16'h0002);
        drive(4'd0, 16'h0010, 16'h0020);
        drive(4'd0, 16'h0100, 16'h0200);
      end
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle(3);

    // Opcode 1000: multiply when enabled, otherwise illegal.
    drive(4'd8, 16'h0102, 16'h0003);
    drive(4'd8, 16'h1000, 16'h0010);
    drive(4'd8, 16'hFFFF, 16'hFFFF);
    drive(4'd0, 16'h0005, 16'h0006);
    idle(W + 4);

    // Reset while a result is held.
    out_ready = 1'b0;
    drive(4'd0, 16'h1111, 16'h2222);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_out_valid", out_valid, 1'b0);
    chk("rst_hold_result", result, 16'h0000);
    chk("rst_hold_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b00000);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of an opcode-1000 operation abandons it.
    drive(4'd8, 16'h0007, 16'h0009);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(W + 4);
    drive(4'd0, 16'h0002, 16'h0003);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
